// File: rtl/cordic_arbiter.sv
// Round-robin arbiter sharing one iterative CORDIC core between several
// requesters, with a tagged response channel and a done-watchdog.
module cordic_arbiter #(
    parameter int unsigned Width         = 16,
    parameter int unsigned NumReq        = 4,
    parameter int unsigned TimeoutCycles = 64
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic [NumReq-1:0]           req_valid_i,
    output logic [NumReq-1:0]           req_ready_o,
    input  logic [NumReq*Width-1:0]     req_x_i,
    input  logic [NumReq*Width-1:0]     req_y_i,
    input  logic [NumReq*Width-1:0]     req_z_i,
    output logic                        rsp_valid_o,
    input  logic                        rsp_ready_i,
    output logic [$clog2(NumReq)-1:0]   rsp_id_o,
    output logic [Width-1:0]            rsp_x_o,
    output logic [Width-1:0]            rsp_y_o,
    output logic [Width-1:0]            rsp_z_o,
    output logic                        rsp_timeout_o,
    output logic                        start_cordic_o,
    output logic [Width-1:0]            x0_o,
    output logic [Width-1:0]            y0_o,
    output logic [Width-1:0]            z0_o,
    input  logic [Width-1:0]            xn_i,
    input  logic [Width-1:0]            yn_i,
    input  logic [Width-1:0]            zn_i,
    input  logic                        done_tick_cordic_i,
    output logic                        busy_o
);

    localparam int unsigned IdW  = $clog2(NumReq);
    localparam int unsigned CntW = $clog2(TimeoutCycles);
    localparam logic [CntW-1:0] CntLast = CntW'(TimeoutCycles - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [IdW-1:0]  last_grant;
    logic [IdW-1:0]  cur_id;
    logic [IdW-1:0]  grant_id;
    logic [IdW-1:0]  cand;
    logic            grant_vld;
    logic [CntW-1:0] cnt;
    logic            timeout_hit;

    assign timeout_hit = (cnt == CntLast);

    // Round-robin search starting just after the last served requester
    always_comb begin
        grant_vld = 1'b0;
        grant_id  = '0;
        cand      = '0;
        for (int unsigned i = 1; i <= NumReq; i++) begin
            cand = IdW'((32'(last_grant) + i) % NumReq);
            if (!grant_vld && req_valid_i[cand]) begin
                grant_vld = 1'b1;
                grant_id  = cand;
            end
        end
    end

    // Next-state logic and the same-cycle request accept
    always_comb begin
        state_nxt   = state;
        req_ready_o = '0;
        case (state)
            IDLE: begin
                if (grant_vld) begin
                    req_ready_o[grant_id] = !rst_i;
                    state_nxt             = START;
                end
            end
            START:   state_nxt = WAIT;
            WAIT: begin
                if (done_tick_cordic_i || timeout_hit) begin
                    state_nxt = RESP;
                end
            end
            RESP: begin
                if (rsp_ready_i) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State register plus registered start/busy flags
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state          <= IDLE;
            start_cordic_o <= 1'b0;
            busy_o         <= 1'b0;
        end else begin
            state          <= state_nxt;
            start_cordic_o <= (state_nxt == START);
            busy_o         <= (state_nxt != IDLE);
        end
    end

    // Operand capture, watchdog counter, response capture and pointer update
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            last_grant    <= IdW'(NumReq - 1);
            cur_id        <= '0;
            cnt           <= '0;
            x0_o          <= '0;
            y0_o          <= '0;
            z0_o          <= '0;
            rsp_valid_o   <= 1'b0;
            rsp_id_o      <= '0;
            rsp_x_o       <= '0;
            rsp_y_o       <= '0;
            rsp_z_o       <= '0;
            rsp_timeout_o <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_vld) begin
                        x0_o   <= req_x_i[32'(grant_id)*Width +: Width];
                        y0_o   <= req_y_i[32'(grant_id)*Width +: Width];
                        z0_o   <= req_z_i[32'(grant_id)*Width +: Width];
                        cur_id <= grant_id;
                        cnt    <= '0;
                    end
                end
                START: cnt <= cnt + CntW'(1);
                WAIT: begin
                    cnt <= cnt + CntW'(1);
                    if (done_tick_cordic_i) begin
                        rsp_valid_o   <= 1'b1;
                        rsp_id_o      <= cur_id;
                        rsp_x_o       <= xn_i;
                        rsp_y_o       <= yn_i;
                        rsp_z_o       <= zn_i;
                        rsp_timeout_o <= 1'b0;
                    end else if (timeout_hit) begin
                        rsp_valid_o   <= 1'b1;
                        rsp_id_o      <= cur_id;
                        rsp_x_o       <= '0;
                        rsp_y_o       <= '0;
                        rsp_z_o       <= '0;
                        rsp_timeout_o <= 1'b1;
                    end
                end
                RESP: begin
                    if (rsp_ready_i) begin
                        rsp_valid_o <= 1'b0;
                        last_grant  <= rsp_id_o;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cordic_arbiter.sv
// Directed bench for cordic_arbiter with a fixed-latency stub core.
module tb_cordic_arbiter;

    localparam int unsigned Width  = 16;
    localparam int unsigned NumReq = 4;
    localparam int unsigned IdW    = 2;

    logic                    clk = 1'b0;
    logic                    rst = 1'b0;
    logic [NumReq-1:0]       req_valid = '0;
    logic [NumReq-1:0]       req_ready;
    logic [NumReq*Width-1:0] req_x = '0;
    logic [NumReq*Width-1:0] req_y = '0;
    logic [NumReq*Width-1:0] req_z = '0;
    logic                    rsp_valid;
    logic                    rsp_ready = 1'b0;
    logic [IdW-1:0]          rsp_id;
    logic [Width-1:0]        rsp_x, rsp_y, rsp_z;
    logic                    rsp_timeout;
    logic                    start;
    logic [Width-1:0]        x0, y0, z0;
    logic [Width-1:0]        xn = '0;
    logic [Width-1:0]        yn = '0;
    logic [Width-1:0]        zn = '0;
    logic                    done_tick = 1'b0;
    logic                    busy;

    int vectors = 0;
    int errors  = 0;
    int cyc     = 0;

    cordic_arbiter dut (
        .clk_i              (clk),
        .rst_i              (rst),
        .req_valid_i        (req_valid),
        .req_ready_o        (req_ready),
        .req_x_i            (req_x),
        .req_y_i            (req_y),
        .req_z_i            (req_z),
        .rsp_valid_o        (rsp_valid),
        .rsp_ready_i        (rsp_ready),
        .rsp_id_o           (rsp_id),
        .rsp_x_o            (rsp_x),
        .rsp_y_o            (rsp_y),
        .rsp_z_o            (rsp_z),
        .rsp_timeout_o      (rsp_timeout),
        .start_cordic_o     (start),
        .x0_o               (x0),
        .y0_o               (y0),
        .z0_o               (z0),
        .xn_i               (xn),
        .yn_i               (yn),
        .zn_i               (zn),
        .done_tick_cordic_i (done_tick),
        .busy_o             (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Stub core: done pulses stub_lat cycles after the start pulse;
    // results are x^A5A5, y+1, z-1 of the launched operands.
    logic             stub_en  = 1'b1;
    int               stub_lat = 16;
    logic             stub_busy = 1'b0;
    int               stub_cnt  = 0;
    logic [Width-1:0] sx = '0, sy = '0, sz = '0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            stub_busy <= 1'b0;
            done_tick <= 1'b0;
        end else begin
            done_tick <= 1'b0;
            if (start) begin
                stub_busy <= 1'b1;
                stub_cnt  <= 1;
                sx <= x0;
                sy <= y0;
                sz <= z0;
            end else if (stub_busy) begin
                if (stub_en && stub_cnt == stub_lat - 1) begin
                    done_tick <= 1'b1;
                    xn <= sx ^ 16'hA5A5;
                    yn <= sy + 16'd1;
                    zn <= sz - 16'd1;
                    stub_busy <= 1'b0;
                end
                stub_cnt <= stub_cnt + 1;
            end
        end
    end

    task automatic set_req(input int k, input logic [Width-1:0] x,
                           input logic [Width-1:0] y, input logic [Width-1:0] z);
        req_x[k*Width +: Width] = x;
        req_y[k*Width +: Width] = y;
        req_z[k*Width +: Width] = z;
        req_valid[k] = 1'b1;
    endtask

    task automatic wait_ready(output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 200; n++) begin
            #1;
            if (req_ready !== '0) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic wait_rsp(output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 200; n++) begin
            #1;
            if (rsp_valid === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic ack();
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        req_valid = '0;
        rsp_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        req_valid = 4'b1111;
        #1;
        vectors++;
        if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b expected 0", rsp_valid); end
        vectors++;
        if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_req_ready: got %b expected 0000", req_ready); end
        vectors++;
        if ({start, busy, rsp_timeout} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b expected 000", {start, busy, rsp_timeout}); end
        vectors++;
        if ({x0, y0, z0, rsp_x, rsp_y, rsp_z, rsp_id} !== '0) begin errors++; $display("FAIL reset_data: got %h expected 0", {x0, y0, z0, rsp_x, rsp_y, rsp_z, rsp_id}); end
        req_valid = '0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        #1;
        vectors++;
        if ({busy, start} !== 2'b00) begin errors++; $display("FAIL reset_idle: got %b expected 00", {busy, start}); end
    endtask

    task automatic test_single();
        bit ok;
        int ta;
        stub_en = 1'b1;
        stub_lat = 16;
        @(negedge clk);
        set_req(2, 16'h26DD, 16'h0000, 16'h2183);
        wait_ready(ok);
        ta = cyc;
        vectors++;
        if (!ok || req_ready !== 4'b0100) begin errors++; $display("FAIL single_ready: got %b expected 0100", req_ready); end
        @(negedge clk);
        req_valid[2] = 1'b0;
        #1;
        vectors++;
        if (start !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL single_start: got start=%b busy=%b expected 1 1", start, busy); end
        vectors++;
        if ({x0, y0, z0} !== {16'h26DD, 16'h0000, 16'h2183}) begin errors++; $display("FAIL single_operands: got %h expected 26dd00002183", {x0, y0, z0}); end
        @(negedge clk);
        #1;
        vectors++;
        if (start !== 1'b0) begin errors++; $display("FAIL single_start_width: got %b expected 0", start); end
        wait_rsp(ok);
        vectors++;
        if (!ok || cyc - ta != 18) begin errors++; $display("FAIL single_latency: got %0d expected 18", cyc - ta); end
        vectors++;
        if ({rsp_id, rsp_timeout} !== {2'd2, 1'b0}) begin errors++; $display("FAIL single_id: got id=%0d to=%b expected 2 0", rsp_id, rsp_timeout); end
        vectors++;
        if ({rsp_x, rsp_y, rsp_z} !== {16'h8378, 16'h0001, 16'h2182}) begin errors++; $display("FAIL single_result: got %h expected 837800012182", {rsp_x, rsp_y, rsp_z}); end
        ack();
        #1;
        vectors++;
        if ({rsp_valid, busy} !== 2'b00) begin errors++; $display("FAIL single_done: got %b expected 00", {rsp_valid, busy}); end
    endtask

    task automatic test_fairness();
        bit ok;
        int order [6] = '{0, 1, 2, 3, 0, 1};
        logic [Width-1:0] xs [4] = '{16'h1000, 16'h2000, 16'h3000, 16'h4000};
        logic [Width-1:0] xe [4] = '{16'hB5A5, 16'h85A5, 16'h95A5, 16'hE5A5};
        logic [NumReq-1:0] onehot;
        do_reset();
        stub_lat = 3;
        rsp_ready = 1'b1;
        for (int k = 0; k < 4; k++) set_req(k, xs[k], 16'h0, 16'h0);
        for (int g = 0; g < 6; g++) begin
            onehot = '0;
            onehot[order[g]] = 1'b1;
            wait_ready(ok);
            vectors++;
            if (!ok || req_ready !== onehot) begin errors++; $display("FAIL fair_grant%0d: got %b expected %b", g, req_ready, onehot); end
            @(negedge clk);
            wait_rsp(ok);
            vectors++;
            if (!ok || rsp_id !== IdW'(order[g]) || rsp_x !== xe[order[g]]) begin
                errors++;
                $display("FAIL fair_rsp%0d: got id=%0d x=%h expected id=%0d x=%h", g, rsp_id, rsp_x, order[g], xe[order[g]]);
            end
            @(negedge clk);
        end
        req_valid = '0;
        rsp_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        bit ok;
        int bad;
        stub_lat = 4;
        @(negedge clk);
        set_req(1, 16'h1234, 16'h5678, 16'h9ABC);
        wait_ready(ok);
        vectors++;
        if (!ok || req_ready !== 4'b0010) begin errors++; $display("FAIL bp_ready: got %b expected 0010", req_ready); end
        @(negedge clk);
        req_valid[1] = 1'b0;
        wait_rsp(ok);
        set_req(0, 16'h0F0F, 16'hF0F0, 16'h3C3C);
        bad = ok ? 0 : 1;
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            #1;
            if (rsp_valid !== 1'b1 || rsp_id !== 2'd1 || rsp_timeout !== 1'b0 ||
                {rsp_x, rsp_y, rsp_z} !== {16'hB791, 16'h5679, 16'h9ABB} ||
                req_ready !== 4'b0000 || start !== 1'b0) bad++;
        end
        vectors++;
        if (bad != 0) begin errors++; $display("FAIL bp_hold: got %0d unstable cycles expected 0", bad); end
        ack();
        #1;
        vectors++;
        if ({rsp_valid, req_ready} !== 5'b0_0001) begin errors++; $display("FAIL bp_release: got %b expected 00001", {rsp_valid, req_ready}); end
        @(negedge clk);
        req_valid[0] = 1'b0;
        wait_rsp(ok);
        vectors++;
        if (!ok || {rsp_id, rsp_x, rsp_y, rsp_z} !== {2'd0, 16'hAAAA, 16'hF0F1, 16'h3C3B}) begin
            errors++;
            $display("FAIL bp_next: got id=%0d %h expected 0 aaaaf0f13c3b", rsp_id, {rsp_x, rsp_y, rsp_z});
        end
        ack();
    endtask

    task automatic test_timeout();
        bit ok;
        int ta;
        stub_en = 1'b0;
        @(negedge clk);
        set_req(3, 16'h1111, 16'h2222, 16'h3333);
        wait_ready(ok);
        ta = cyc;
        @(negedge clk);
        req_valid[3] = 1'b0;
        wait_rsp(ok);
        vectors++;
        if (!ok || cyc - ta != 65) begin errors++; $display("FAIL to_latency: got %0d expected 65", cyc - ta); end
        vectors++;
        if ({rsp_timeout, rsp_id} !== {1'b1, 2'd3}) begin errors++; $display("FAIL to_flag: got to=%b id=%0d expected 1 3", rsp_timeout, rsp_id); end
        vectors++;
        if ({rsp_x, rsp_y, rsp_z} !== '0) begin errors++; $display("FAIL to_data: got %h expected 0", {rsp_x, rsp_y, rsp_z}); end
        ack();
        stub_en = 1'b1;
        stub_lat = 16;
        set_req(0, 16'h0001, 16'h0002, 16'h0003);
        wait_ready(ok);
        ta = cyc;
        @(negedge clk);
        req_valid[0] = 1'b0;
        wait_rsp(ok);
        vectors++;
        if (!ok || cyc - ta != 18 || rsp_timeout !== 1'b0 ||
            {rsp_id, rsp_x, rsp_y, rsp_z} !== {2'd0, 16'hA5A4, 16'h0003, 16'h0002}) begin
            errors++;
            $display("FAIL to_recover: got lat=%0d to=%b id=%0d %h expected 18 0 0 a5a400030002", cyc - ta, rsp_timeout, rsp_id, {rsp_x, rsp_y, rsp_z});
        end
        ack();
    endtask

    task automatic test_done_at_timeout();
        bit ok;
        int ta;
        stub_en = 1'b1;
        stub_lat = 63;
        @(negedge clk);
        set_req(2, 16'hFFFF, 16'h8000, 16'h0000);
        wait_ready(ok);
        ta = cyc;
        @(negedge clk);
        req_valid[2] = 1'b0;
        wait_rsp(ok);
        vectors++;
        if (!ok || cyc - ta != 65) begin errors++; $display("FAIL dt_latency: got %0d expected 65", cyc - ta); end
        vectors++;
        if (rsp_timeout !== 1'b0 || {rsp_id, rsp_x, rsp_y, rsp_z} !== {2'd2, 16'h5A5A, 16'h8001, 16'hFFFF}) begin
            errors++;
            $display("FAIL dt_result: got to=%b id=%0d %h expected 0 2 5a5a8001ffff", rsp_timeout, rsp_id, {rsp_x, rsp_y, rsp_z});
        end
        ack();
    endtask

    task automatic test_async_reset();
        bit ok;
        stub_lat = 16;
        @(negedge clk);
        set_req(1, 16'h4321, 16'h8765, 16'hCBA9);
        wait_ready(ok);
        @(negedge clk);
        req_valid[1] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        vectors++;
        if (busy !== 1'b1) begin errors++; $display("FAIL ar_busy: got %b expected 1", busy); end
        #2;
        req_valid = 4'b1001;
        rst = 1'b1;
        #1;
        vectors++;
        if ({rsp_valid, req_ready, start, busy, rsp_timeout} !== 8'h00 ||
            {x0, y0, z0, rsp_x, rsp_y, rsp_z, rsp_id} !== '0) begin
            errors++;
            $display("FAIL ar_outputs: got ctl=%b data=%h expected 0", {rsp_valid, req_ready, start, busy, rsp_timeout}, {x0, y0, z0, rsp_x, rsp_y, rsp_z, rsp_id});
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        wait_ready(ok);
        vectors++;
        if (!ok || req_ready !== 4'b0001) begin errors++; $display("FAIL ar_priority: got %b expected 0001", req_ready); end
        @(negedge clk);
        req_valid = '0;
        wait_rsp(ok);
        vectors++;
        if (!ok || rsp_id !== 2'd0) begin errors++; $display("FAIL ar_rsp: got id=%0d expected 0", rsp_id); end
        ack();
    endtask

    initial begin
        test_reset();
        test_single();
        test_fairness();
        test_backpressure();
        test_timeout();
        test_done_at_timeout();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/cordic_arbiter.md
Name: cordic_arbiter

Overview:
Shares a single iterative CORDIC core between NumReq independent requesters. Requests are accepted over per-requester valid/ready channels and arbitrated round-robin. The block launches the core with the winner's operands, captures the result on the core's done tick, and returns it on a single tagged response channel. A watchdog recovers from a core that never signals done.

Parameters:
Width, 16, operand/result bit width (matches core Width)
NumReq, 4, number of requesters (2..8)
TimeoutCycles, 64, max cycles waited for done_tick_cordic_i before abort (>=2)

Ports:
clk_i  input  1  clock
rst_i  input  1  asynchronous active-high reset
req_valid_i  input  NumReq  per-requester request valid
req_ready_o  output  NumReq  per-requester accept, at most one bit high
req_x_i  input  NumReq*Width  packed x0 operands, requester k at [k*Width +: Width]
req_y_i  input  NumReq*Width  packed y0 operands
req_z_i  input  NumReq*Width  packed z0 operands
rsp_valid_o  output  1  response valid
rsp_ready_i  input  1  response accept
rsp_id_o  output  $clog2(NumReq)  index of requester that owns the response
rsp_x_o  output  Width  captured xn
rsp_y_o  output  Width  captured yn
rsp_z_o  output  Width  captured zn
rsp_timeout_o  output  1  response is a timeout abort; results are zero
start_cordic_o  output  1  one-cycle start pulse to core
x0_o  output  Width  operand to core
y0_o  output  Width  operand to core
z0_o  output  Width  operand to core
xn_i  input  Width  core result
yn_i  input  Width  core result
zn_i  input  Width  core result
done_tick_cordic_i  input  1  core completion pulse
busy_o  output  1  high in any state other than IDLE

Behaviour:
- Reset (async, rst_i=1): state IDLE; all outputs 0; round-robin pointer set so requester 0 has highest priority (last_grant = NumReq-1); timeout counter 0.
- FSM states: IDLE, START, WAIT, RESP.
- IDLE: if any req_valid_i is set, the grant g is the first set bit scanning from last_grant+1 with wrap-around. req_ready_o[g]=1 combinationally in the same cycle, and the handshake completes that cycle. Operands of g and the id are registered, then go to START. If no valid bit is set, stay in IDLE with req_ready_o=0.
- START: start_cordic_o=1 for exactly one cycle; go to WAIT; timeout counter cleared.
- x0_o/y0_o/z0_o hold the registered operands from START through the end of WAIT and keep them until the next grant.
- WAIT: the counter increments each cycle.
  - done_tick_cordic_i=1: capture xn_i/yn_i/zn_i; rsp_timeout_o=0; go to RESP.
  - Counter reaches TimeoutCycles-1 with no done: results 0; rsp_timeout_o=1; go to RESP.
  - Done arriving on the same cycle as the timeout: done wins.
- RESP: rsp_valid_o=1. rsp_id_o, rsp_*_o and rsp_timeout_o are held stable until rsp_ready_i=1. On the handshake, last_grant becomes g, then go to IDLE. No request is accepted while in RESP; the core is not restarted.
- done_tick_cordic_i outside WAIT is ignored.
- Latency: request accepted at cycle T → start at T+1 → core done at T+1+L → rsp_valid_o at T+2+L.
- req_valid_i deasserting on a non-granted requester has no effect. Requesters must hold valid and operands until ready.
- Reset mid-operation returns to IDLE immediately. Any in-flight result is discarded and no response is emitted.

Test Plan:
- Single request: stub core with L=16; requester 2 sends x=0x26DD, y=0, z=0x2183 → ready[2] for 1 cycle; start pulse 1 cycle later; rsp_valid 18 cycles after accept; rsp_id=2, rsp values equal stub outputs, timeout=0.
- Fairness: all 4 valid continuously, rsp_ready_i=1 → grant order 0,1,2,3,0,1; never two ready bits high at once.
- Backpressure: rsp_ready_i=0 for 10 cycles after rsp_valid → outputs stable, no new req_ready_o, no start pulse; accept completes on the first ready cycle.
- Timeout: stub never pulses done, TimeoutCycles=64 → rsp_valid with rsp_timeout_o=1, results 0, exactly 64 cycles after start; next request is served normally.
- Done on the timeout cycle: stub done at counter 63 → rsp_timeout_o=0, stub results returned.
- Async reset asserted in WAIT → all outputs 0 without waiting for a clock edge; after release, requester 0 wins when 0 and 3 request together.
